// File: rtl/eth_pkg.sv
// Shared state encoding, framing constants and byte-wide CRC-32 step for the Ethernet transmit path.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam int          PREAMBLE_LEN  = 7;
    localparam int          FCS_LEN       = 4;

    // Reflected CRC-32 advanced by one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-serial CRC-32 register; state updates one cycle after en_i, clr_i has priority.
// crc_nxt_o exposes the state that would result from absorbing data_i this cycle.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o,
    output logic [31:0] crc_nxt_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    assign crc_d     = crc32_byte(crc_q, data_i);
    assign crc_nxt_o = crc_d;
    assign crc_o     = crc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            crc_q <= CRC_INIT;
        end else if (clr_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Frames buffered payload into preamble/SFD/payload/pad/FCS/IFG; first preamble byte one cycle after start.
// No backpressure on txd; an empty buffer at a required read aborts the frame without FCS.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_DATA   = 60,
    parameter int MAX_DATA   = 1500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] frame_len,
    input  logic [7:0]  fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_read,
    output logic [7:0]  txd,
    output logic        tx_en,
    output logic        busy,
    output logic        done,
    output logic        err_len,
    output logic        err_underrun
);

    tx_state_t   state_q;
    logic [10:0] cnt_q;
    logic [10:0] len_q;
    logic [10:0] rd_left_q;
    logic        rd_vld_q;
    logic        uflow_q;
    logic [7:0]  txd_q;
    logic        tx_en_q;
    logic        done_q;
    logic        err_len_q;
    logic        err_underrun_q;

    logic        rd_req;
    logic        need_byte;
    logic        crc_en;
    logic        crc_clr;
    logic [31:0] crc_q;
    logic [31:0] crc_nxt;
    logic [31:0] fcs_word;
    logic [1:0]  fcs_sel;
    logic [7:0]  fcs_byte;

    // Reads run two cycles ahead of txd: buffer register plus our output register.
    assign rd_req = rst_n && !uflow_q && (rd_left_q != 11'd0) &&
                    ((state_q == ST_PREAMBLE && cnt_q == 11'(PREAMBLE_LEN - 1)) ||
                     state_q == ST_SFD || state_q == ST_PAYLOAD);
    assign fifo_read = rd_req && !fifo_empty;

    assign need_byte = (state_q == ST_SFD) ||
                       (state_q == ST_PAYLOAD && cnt_q != len_q - 11'd1);

    // CRC absorbs the byte currently on txd, so the first FCS byte needs the look-ahead value.
    assign crc_clr  = (state_q == ST_SFD);
    assign crc_en   = (state_q == ST_PAYLOAD) || (state_q == ST_PAD);
    assign fcs_word = (state_q == ST_FCS) ? crc_q : crc_nxt;
    assign fcs_sel  = (state_q == ST_FCS) ? cnt_q[1:0] + 2'd1 : 2'd0;
    assign fcs_byte = 8'(~fcs_word >> {fcs_sel, 3'b000});

    crc32_d8 u_crc (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .en_i      (crc_en),
        .clr_i     (crc_clr),
        .data_i    (txd_q),
        .crc_o     (crc_q),
        .crc_nxt_o (crc_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            rd_left_q      <= '0;
            rd_vld_q       <= 1'b0;
            uflow_q        <= 1'b0;
            txd_q          <= '0;
            tx_en_q        <= 1'b0;
            done_q         <= 1'b0;
            err_len_q      <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            done_q         <= 1'b0;
            err_len_q      <= 1'b0;
            err_underrun_q <= 1'b0;
            rd_vld_q       <= fifo_read;
            if (fifo_read) begin
                rd_left_q <= rd_left_q - 11'd1;
            end
            if (rd_req && fifo_empty) begin
                uflow_q        <= 1'b1;
                err_underrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (frame_len != 11'd0 && frame_len <= 11'(MAX_DATA)) begin
                            state_q   <= ST_PREAMBLE;
                            len_q     <= frame_len;
                            rd_left_q <= frame_len;
                            cnt_q     <= '0;
                            uflow_q   <= 1'b0;
                            txd_q     <= PREAMBLE_BYTE;
                            tx_en_q   <= 1'b1;
                        end else begin
                            err_len_q <= 1'b1;
                        end
                    end
                end
                ST_PREAMBLE: begin
                    if (cnt_q == 11'(PREAMBLE_LEN - 1)) begin
                        state_q <= ST_SFD;
                        cnt_q   <= '0;
                        txd_q   <= SFD_BYTE;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
                ST_SFD, ST_PAYLOAD: begin
                    if (need_byte) begin
                        if (rd_vld_q) begin
                            state_q <= ST_PAYLOAD;
                            txd_q   <= fifo_data;
                            cnt_q   <= (state_q == ST_SFD) ? 11'd0 : cnt_q + 11'd1;
                        end else begin
                            // Missing byte: drop tx_en mid-frame so the receiver sees a runt.
                            state_q <= ST_IFG;
                            cnt_q   <= '0;
                            txd_q   <= '0;
                            tx_en_q <= 1'b0;
                        end
                    end else if (len_q < 11'(MIN_DATA)) begin
                        state_q <= ST_PAD;
                        cnt_q   <= cnt_q + 11'd1;
                        txd_q   <= '0;
                    end else begin
                        state_q <= ST_FCS;
                        cnt_q   <= '0;
                        txd_q   <= fcs_byte;
                    end
                end
                ST_PAD: begin
                    if (cnt_q == 11'(MIN_DATA - 1)) begin
                        state_q <= ST_FCS;
                        cnt_q   <= '0;
                        txd_q   <= fcs_byte;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
                ST_FCS: begin
                    if (cnt_q == 11'(FCS_LEN - 1)) begin
                        state_q <= ST_IFG;
                        cnt_q   <= '0;
                        txd_q   <= '0;
                        tx_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                        txd_q <= fcs_byte;
                    end
                end
                ST_IFG: begin
                    if (cnt_q == 11'(IFG_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        done_q  <= !uflow_q;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    txd_q   <= '0;
                    tx_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign txd          = txd_q;
    assign tx_en        = tx_en_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err_len      = err_len_q;
    assign err_underrun = err_underrun_q;

endmodule
